// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the 5-stage core.
//
// Captures decoded fields and register-file operands from decode. Presents
// them to EX under a valid/ready handshake. Also does RAW hazard detection
// (bubble insertion), optional operand forwarding, and branch-flush squashing.
//
// Handshake: a decode instruction transfers on a rising edge where
// i_id_valid && o_id_ready. The held instruction leaves on an edge where
// o_ex_valid && i_ex_ready. The register only loads when it is empty or
// draining (advance). Otherwise every register holds.
//
// Configuration macro: ID_EX_FWD_EN
//   defined   : forward from EX (non-load held here) and MEM. Stall only on
//               a load held here, giving a one-bubble load-use penalty.
//   undefined : operands come from the register file only. Stall on any
//               valid held writer and on a MEM-stage writer. The register
//               file bypass covers WB.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_id_*                  decode instruction and handshake (o_id_ready)
//   i_ex_ready              EX accepts the held instruction
//   i_ex_result             EX result of the held instruction (forwarding)
//   i_mem_rd_*              MEM-stage writeback info (hazard/forwarding)
//   i_flush                 squash the held and the decode instruction
//   o_ex_*                  registered payload presented to EX
//   o_stall                 hazard stall asserted this cycle
module id_ex_stage #(
  parameter int CTRL_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_valid,
  output logic              o_id_ready,
  input  logic [31:0]       i_id_pc,
  input  logic [4:0]        i_id_rs1_addr,
  input  logic [4:0]        i_id_rs2_addr,
  input  logic              i_id_rs1_used,
  input  logic              i_id_rs2_used,
  input  logic [31:0]       i_id_rs1_data,
  input  logic [31:0]       i_id_rs2_data,
  input  logic [31:0]       i_id_imm,
  input  logic              i_id_rd_wen,
  input  logic [4:0]        i_id_rd_waddr,
  input  logic              i_id_is_load,
  input  logic [CTRL_W-1:0] i_id_ctrl,
  input  logic              i_ex_ready,
  input  logic [31:0]       i_ex_result,
  input  logic              i_mem_rd_wen,
  input  logic [4:0]        i_mem_rd_waddr,
  input  logic [31:0]       i_mem_rd_wdata,
  input  logic              i_flush,
  output logic              o_ex_valid,
  output logic [31:0]       o_ex_pc,
  output logic [31:0]       o_ex_imm,
  output logic [31:0]       o_ex_rs1_data,
  output logic [31:0]       o_ex_rs2_data,
  output logic              o_ex_rd_wen,
  output logic [4:0]        o_ex_rd_waddr,
  output logic              o_ex_is_load,
  output logic [CTRL_W-1:0] o_ex_ctrl,
  output logic              o_stall
);

  logic              r_ex_valid;
  logic [31:0]       r_ex_pc;
  logic [31:0]       r_ex_imm;
  logic [31:0]       r_ex_rs1_data;
  logic [31:0]       r_ex_rs2_data;
  logic              r_ex_rd_wen;
  logic [4:0]        r_ex_rd_waddr;
  logic              r_ex_is_load;
  logic [CTRL_W-1:0] r_ex_ctrl;

  logic        w_advance;
  logic        w_hazard;
  logic        w_id_ready;
  logic        w_stall_a_wen;  // stall source held in this stage
  logic        w_stall_b_wen;  // stall source in MEM
  logic        w_fwd_ex_wen;
  logic        w_fwd_mem_wen;
  logic [31:0] w_rs1_op;
  logic [31:0] w_rs2_op;

  // x0 never matches, so it never stalls or forwards.
  function automatic logic match(input logic used, input logic [4:0] src,
                                 input logic wen, input logic [4:0] dst);
    return used && (src != 5'd0) && (src == dst) && wen;
  endfunction

`ifdef ID_EX_FWD_EN
  // A load's data is not ready until MEM, so only a held load stalls.
  assign w_stall_a_wen = r_ex_valid && r_ex_is_load && r_ex_rd_wen;
  assign w_stall_b_wen = 1'b0;
  assign w_fwd_ex_wen  = r_ex_valid && !r_ex_is_load && r_ex_rd_wen;
  assign w_fwd_mem_wen = i_mem_rd_wen;
`else
  assign w_stall_a_wen = r_ex_valid && r_ex_rd_wen;
  assign w_stall_b_wen = i_mem_rd_wen;
  assign w_fwd_ex_wen  = 1'b0;
  assign w_fwd_mem_wen = 1'b0;
`endif

  assign w_advance = !r_ex_valid || i_ex_ready;

  assign w_hazard = i_id_valid && (
      match(i_id_rs1_used, i_id_rs1_addr, w_stall_a_wen, r_ex_rd_waddr) ||
      match(i_id_rs2_used, i_id_rs2_addr, w_stall_a_wen, r_ex_rd_waddr) ||
      match(i_id_rs1_used, i_id_rs1_addr, w_stall_b_wen, i_mem_rd_waddr) ||
      match(i_id_rs2_used, i_id_rs2_addr, w_stall_b_wen, i_mem_rd_waddr));

  assign w_id_ready = !i_rst && w_advance && !w_hazard && !i_flush;

  // Operand select: x0, then EX (youngest), then MEM, then register file.
  always_comb begin
    w_rs1_op = i_id_rs1_data;
    if (i_id_rs1_addr == 5'd0)
      w_rs1_op = 32'd0;
    else if (match(i_id_rs1_used, i_id_rs1_addr, w_fwd_ex_wen, r_ex_rd_waddr))
      w_rs1_op = i_ex_result;
    else if (match(i_id_rs1_used, i_id_rs1_addr, w_fwd_mem_wen, i_mem_rd_waddr))
      w_rs1_op = i_mem_rd_wdata;
  end

  always_comb begin
    w_rs2_op = i_id_rs2_data;
    if (i_id_rs2_addr == 5'd0)
      w_rs2_op = 32'd0;
    else if (match(i_id_rs2_used, i_id_rs2_addr, w_fwd_ex_wen, r_ex_rd_waddr))
      w_rs2_op = i_ex_result;
    else if (match(i_id_rs2_used, i_id_rs2_addr, w_fwd_mem_wen, i_mem_rd_waddr))
      w_rs2_op = i_mem_rd_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex_valid    <= 1'b0;
      r_ex_pc       <= '0;
      r_ex_imm      <= '0;
      r_ex_rs1_data <= '0;
      r_ex_rs2_data <= '0;
      r_ex_rd_wen   <= 1'b0;
      r_ex_rd_waddr <= '0;
      r_ex_is_load  <= 1'b0;
      r_ex_ctrl     <= '0;
    end else if (i_flush) begin
      // Squash even when EX is back-pressuring us.
      r_ex_valid  <= 1'b0;
      r_ex_rd_wen <= 1'b0;
    end else if (w_advance) begin
      if (i_id_valid && w_id_ready) begin
        r_ex_valid    <= 1'b1;
        r_ex_pc       <= i_id_pc;
        r_ex_imm      <= i_id_imm;
        r_ex_rs1_data <= w_rs1_op;
        r_ex_rs2_data <= w_rs2_op;
        r_ex_rd_wen   <= i_id_rd_wen;
        r_ex_rd_waddr <= i_id_rd_waddr;
        r_ex_is_load  <= i_id_is_load;
        r_ex_ctrl     <= i_id_ctrl;
      end else begin
        // Bubble: payload kept, but it must never look like a writer.
        r_ex_valid  <= 1'b0;
        r_ex_rd_wen <= 1'b0;
      end
    end
  end

  assign o_id_ready    = w_id_ready;
  assign o_stall       = !i_rst && w_hazard && !i_flush;
  assign o_ex_valid    = r_ex_valid;
  assign o_ex_pc       = r_ex_pc;
  assign o_ex_imm      = r_ex_imm;
  assign o_ex_rs1_data = r_ex_rs1_data;
  assign o_ex_rs2_data = r_ex_rs2_data;
  assign o_ex_rd_wen   = r_ex_rd_wen;
  assign o_ex_rd_waddr = r_ex_rd_waddr;
  assign o_ex_is_load  = r_ex_is_load;
  assign o_ex_ctrl     = r_ex_ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage. The expectations follow the build
// configuration (ID_EX_FWD_EN defined or not).
module tb_id_ex_stage;

  localparam int CTRL_W = 16;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_id_valid;
  logic              o_id_ready;
  logic [31:0]       i_id_pc;
  logic [4:0]        i_id_rs1_addr, i_id_rs2_addr;
  logic              i_id_rs1_used, i_id_rs2_used;
  logic [31:0]       i_id_rs1_data, i_id_rs2_data;
  logic [31:0]       i_id_imm;
  logic              i_id_rd_wen;
  logic [4:0]        i_id_rd_waddr;
  logic              i_id_is_load;
  logic [CTRL_W-1:0] i_id_ctrl;
  logic              i_ex_ready;
  logic [31:0]       i_ex_result;
  logic              i_mem_rd_wen;
  logic [4:0]        i_mem_rd_waddr;
  logic [31:0]       i_mem_rd_wdata;
  logic              i_flush;
  logic              o_ex_valid;
  logic [31:0]       o_ex_pc, o_ex_imm, o_ex_rs1_data, o_ex_rs2_data;
  logic              o_ex_rd_wen;
  logic [4:0]        o_ex_rd_waddr;
  logic              o_ex_is_load;
  logic [CTRL_W-1:0] o_ex_ctrl;
  logic              o_stall;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.CTRL_W(CTRL_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_id_valid(i_id_valid), .o_id_ready(o_id_ready),
    .i_id_pc(i_id_pc),
    .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
    .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used),
    .i_id_rs1_data(i_id_rs1_data), .i_id_rs2_data(i_id_rs2_data),
    .i_id_imm(i_id_imm), .i_id_rd_wen(i_id_rd_wen), .i_id_rd_waddr(i_id_rd_waddr),
    .i_id_is_load(i_id_is_load), .i_id_ctrl(i_id_ctrl),
    .i_ex_ready(i_ex_ready), .i_ex_result(i_ex_result),
    .i_mem_rd_wen(i_mem_rd_wen), .i_mem_rd_waddr(i_mem_rd_waddr),
    .i_mem_rd_wdata(i_mem_rd_wdata), .i_flush(i_flush),
    .o_ex_valid(o_ex_valid), .o_ex_pc(o_ex_pc), .o_ex_imm(o_ex_imm),
    .o_ex_rs1_data(o_ex_rs1_data), .o_ex_rs2_data(o_ex_rs2_data),
    .o_ex_rd_wen(o_ex_rd_wen), .o_ex_rd_waddr(o_ex_rd_waddr),
    .o_ex_is_load(o_ex_is_load), .o_ex_ctrl(o_ex_ctrl), .o_stall(o_stall)
  );

  // Clock / reset block
  always #5 i_clk = ~i_clk;

  // Driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_id(input logic [31:0] pc,
                          input logic [4:0] rs1, input logic u1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic u2, input logic [31:0] d2,
                          input logic [31:0] imm, input logic wen, input logic [4:0] rd,
                          input logic ld, input logic [CTRL_W-1:0] ctrl);
    i_id_valid = 1'b1;
    i_id_pc = pc;
    i_id_rs1_addr = rs1; i_id_rs1_used = u1; i_id_rs1_data = d1;
    i_id_rs2_addr = rs2; i_id_rs2_used = u2; i_id_rs2_data = d2;
    i_id_imm = imm; i_id_rd_wen = wen; i_id_rd_waddr = rd;
    i_id_is_load = ld; i_id_ctrl = ctrl;
    #1;
  endtask

  task automatic idle_id();
    i_id_valid = 1'b0;
    i_id_rs1_used = 1'b0;
    i_id_rs2_used = 1'b0;
    #1;
  endtask

  // Test tasks
  task automatic test_reset();
    i_rst = 1'b1;
    i_ex_ready = 1'b1; i_ex_result = 32'h0; i_flush = 1'b0;
    i_mem_rd_wen = 1'b0; i_mem_rd_waddr = 5'd0; i_mem_rd_wdata = 32'h0;
    drive_id(32'hAAAA_0000, 5'd1, 1'b1, 32'h1, 5'd2, 1'b1, 32'h2, 32'h3, 1'b1, 5'd4, 1'b0, 16'hFFFF);
    tick();
    tick();
    checks++; if (o_id_ready !== 1'b0) begin errors++; $display("FAIL reset_id_ready got=%0b exp=0", o_id_ready); end
    checks++; if (o_ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got=%0b exp=0", o_ex_valid); end
    checks++; if (o_ex_rd_wen !== 1'b0) begin errors++; $display("FAIL reset_rd_wen got=%0b exp=0", o_ex_rd_wen); end
    checks++; if (o_ex_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", o_ex_pc); end
    checks++; if (o_ex_ctrl !== 16'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", o_ex_ctrl); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", o_stall); end
    idle_id();
    i_rst = 1'b0;
    #1;
  endtask

  task automatic test_stream();
    // addi x1, x0, 5
    drive_id(32'h100, 5'd0, 1'b1, 32'h0, 5'd0, 1'b0, 32'h0, 32'h5, 1'b1, 5'd1, 1'b0, 16'h0011);
    checks++; if (o_id_ready !== 1'b1) begin errors++; $display("FAIL stream_ready0 got=%0b exp=1", o_id_ready); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL stream_stall0 got=%0b exp=0", o_stall); end
    tick();
    checks++; if (o_ex_valid !== 1'b1) begin errors++; $display("FAIL stream_valid0 got=%0b exp=1", o_ex_valid); end
    checks++; if (o_ex_pc !== 32'h100) begin errors++; $display("FAIL stream_pc0 got=%h exp=100", o_ex_pc); end
    checks++; if (o_ex_imm !== 32'h5) begin errors++; $display("FAIL stream_imm0 got=%h exp=5", o_ex_imm); end
    checks++; if (o_ex_rd_waddr !== 5'd1 || o_ex_rd_wen !== 1'b1) begin errors++; $display("FAIL stream_rd0 got=%0d/%0b exp=1/1", o_ex_rd_waddr, o_ex_rd_wen); end
    checks++; if (o_ex_ctrl !== 16'h0011) begin errors++; $display("FAIL stream_ctrl0 got=%h exp=0011", o_ex_ctrl); end
    // addi x2, x3, 7 : no dependency on x1
    drive_id(32'h104, 5'd3, 1'b1, 32'h33, 5'd0, 1'b0, 32'h0, 32'h7, 1'b1, 5'd2, 1'b0, 16'h0022);
    checks++; if (o_id_ready !== 1'b1 || o_stall !== 1'b0) begin errors++; $display("FAIL stream_ready1 got=%0b/%0b exp=1/0", o_id_ready, o_stall); end
    tick();
    checks++; if (o_ex_valid !== 1'b1 || o_ex_pc !== 32'h104) begin errors++; $display("FAIL stream_pc1 got=%0b/%h exp=1/104", o_ex_valid, o_ex_pc); end
    checks++; if (o_ex_rs1_data !== 32'h33 || o_ex_rd_waddr !== 5'd2) begin errors++; $display("FAIL stream_op1 got=%h/%0d exp=33/2", o_ex_rs1_data, o_ex_rd_waddr); end
    checks++; if (o_ex_ctrl !== 16'h0022) begin errors++; $display("FAIL stream_ctrl1 got=%h exp=0022", o_ex_ctrl); end
    idle_id();
    tick();
    checks++; if (o_ex_valid !== 1'b0 || o_ex_rd_wen !== 1'b0) begin errors++; $display("FAIL stream_drain got=%0b/%0b exp=0/0", o_ex_valid, o_ex_rd_wen); end
  endtask

  task automatic test_ex_hazard();
    // add x5, x1, x2 held; then sub x6, x5, x4
    drive_id(32'h200, 5'd1, 1'b1, 32'h1, 5'd2, 1'b1, 32'h2, 32'h0, 1'b1, 5'd5, 1'b0, 16'h0005);
    tick();
    i_ex_result = 32'h10;
    drive_id(32'h204, 5'd5, 1'b1, 32'h0, 5'd4, 1'b1, 32'h44, 32'h0, 1'b1, 5'd6, 1'b0, 16'h0006);
`ifdef ID_EX_FWD_EN
    checks++; if (o_stall !== 1'b0 || o_id_ready !== 1'b1) begin errors++; $display("FAIL exhz_nostall got=%0b/%0b exp=0/1", o_stall, o_id_ready); end
    tick();
`else
    checks++; if (o_stall !== 1'b1 || o_id_ready !== 1'b0) begin errors++; $display("FAIL exhz_stall0 got=%0b/%0b exp=1/0", o_stall, o_id_ready); end
    tick();
    checks++; if (o_ex_valid !== 1'b0 || o_ex_rd_wen !== 1'b0) begin errors++; $display("FAIL exhz_bubble0 got=%0b/%0b exp=0/0", o_ex_valid, o_ex_rd_wen); end
    // add x5 now in MEM
    i_mem_rd_wen = 1'b1; i_mem_rd_waddr = 5'd5; i_mem_rd_wdata = 32'h10;
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL exhz_stall1 got=%0b exp=1", o_stall); end
    tick();
    checks++; if (o_ex_valid !== 1'b0) begin errors++; $display("FAIL exhz_bubble1 got=%0b exp=0", o_ex_valid); end
    // add x5 in WB: RF bypass supplies the value
    i_mem_rd_wen = 1'b0;
    drive_id(32'h204, 5'd5, 1'b1, 32'h10, 5'd4, 1'b1, 32'h44, 32'h0, 1'b1, 5'd6, 1'b0, 16'h0006);
    checks++; if (o_stall !== 1'b0 || o_id_ready !== 1'b1) begin errors++; $display("FAIL exhz_release got=%0b/%0b exp=0/1", o_stall, o_id_ready); end
    tick();
`endif
    checks++; if (o_ex_valid !== 1'b1 || o_ex_pc !== 32'h204) begin errors++; $display("FAIL exhz_capture got=%0b/%h exp=1/204", o_ex_valid, o_ex_pc); end
    checks++; if (o_ex_rs1_data !== 32'h10) begin errors++; $display("FAIL exhz_rs1 got=%h exp=10", o_ex_rs1_data); end
    checks++; if (o_ex_rs2_data !== 32'h44) begin errors++; $display("FAIL exhz_rs2 got=%h exp=44", o_ex_rs2_data); end
    idle_id();
    i_ex_result = 32'h0;
    tick();
  endtask

  task automatic test_load_use();
    // lw x7 held; then add x8, x7, x0
    drive_id(32'h240, 5'd1, 1'b1, 32'h1, 5'd0, 1'b0, 32'h0, 32'h8, 1'b1, 5'd7, 1'b1, 16'h0007);
    tick();
    i_ex_result = 32'h0000_0BAD;  // address, never a valid forward for a load
    drive_id(32'h244, 5'd7, 1'b1, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd8, 1'b0, 16'h0008);
    checks++; if (o_stall !== 1'b1 || o_id_ready !== 1'b0) begin errors++; $display("FAIL lu_stall0 got=%0b/%0b exp=1/0", o_stall, o_id_ready); end
    tick();
    checks++; if (o_ex_valid !== 1'b0 || o_ex_rd_wen !== 1'b0) begin errors++; $display("FAIL lu_bubble0 got=%0b/%0b exp=0/0", o_ex_valid, o_ex_rd_wen); end
    i_mem_rd_wen = 1'b1; i_mem_rd_waddr = 5'd7; i_mem_rd_wdata = 32'hDEADBEEF;
    #1;
`ifdef ID_EX_FWD_EN
    checks++; if (o_stall !== 1'b0 || o_id_ready !== 1'b1) begin errors++; $display("FAIL lu_release got=%0b/%0b exp=0/1", o_stall, o_id_ready); end
    tick();
`else
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL lu_stall1 got=%0b exp=1", o_stall); end
    tick();
    checks++; if (o_ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble1 got=%0b exp=0", o_ex_valid); end
    i_mem_rd_wen = 1'b0;
    drive_id(32'h244, 5'd7, 1'b1, 32'hDEADBEEF, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd8, 1'b0, 16'h0008);
    checks++; if (o_stall !== 1'b0 || o_id_ready !== 1'b1) begin errors++; $display("FAIL lu_release got=%0b/%0b exp=0/1", o_stall, o_id_ready); end
    tick();
`endif
    checks++; if (o_ex_valid !== 1'b1 || o_ex_rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lu_capture got=%0b/%h exp=1/deadbeef", o_ex_valid, o_ex_rs1_data); end
    i_mem_rd_wen = 1'b0;
    i_ex_result = 32'h0;
    idle_id();
    tick();
  endtask

  task automatic test_backpressure();
    drive_id(32'h300, 5'd1, 1'b1, 32'h1, 5'd0, 1'b0, 32'h0, 32'h30, 1'b1, 5'd9, 1'b0, 16'h0009);
    tick();
    i_ex_ready = 1'b0;
    drive_id(32'h304, 5'd2, 1'b1, 32'h2, 5'd0, 1'b0, 32'h0, 32'h34, 1'b1, 5'd11, 1'b0, 16'h000B);
    for (int i = 0; i < 3; i++) begin
      checks++; if (o_id_ready !== 1'b0 || o_stall !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got=%0b/%0b exp=0/0", i, o_id_ready, o_stall); end
      tick();
      checks++; if (o_ex_valid !== 1'b1 || o_ex_pc !== 32'h300 || o_ex_rd_waddr !== 5'd9 || o_ex_imm !== 32'h30) begin
        errors++; $display("FAIL bp_hold%0d got=%0b/%h/%0d/%h exp=1/300/9/30", i, o_ex_valid, o_ex_pc, o_ex_rd_waddr, o_ex_imm); end
    end
    i_ex_ready = 1'b1;
    #1;
    checks++; if (o_id_ready !== 1'b1) begin errors++; $display("FAIL bp_resume got=%0b exp=1", o_id_ready); end
    tick();
    checks++; if (o_ex_pc !== 32'h304 || o_ex_rd_waddr !== 5'd11) begin errors++; $display("FAIL bp_next got=%h/%0d exp=304/11", o_ex_pc, o_ex_rd_waddr); end
    idle_id();
    tick();
  endtask

  task automatic test_flush();
    // lw x10 held under back-pressure, decode reads x10
    drive_id(32'h400, 5'd1, 1'b1, 32'h1, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd10, 1'b1, 16'h000A);
    tick();
    i_ex_ready = 1'b0;
    drive_id(32'h404, 5'd10, 1'b1, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd12, 1'b0, 16'h000C);
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL fl_hazard got=%0b exp=1", o_stall); end
    i_flush = 1'b1;
    #1;
    checks++; if (o_id_ready !== 1'b0 || o_stall !== 1'b0) begin errors++; $display("FAIL fl_ready got=%0b/%0b exp=0/0", o_id_ready, o_stall); end
    tick();
    checks++; if (o_ex_valid !== 1'b0 || o_ex_rd_wen !== 1'b0) begin errors++; $display("FAIL fl_squash got=%0b/%0b exp=0/0", o_ex_valid, o_ex_rd_wen); end
    i_flush = 1'b0;
    i_ex_ready = 1'b1;
    idle_id();
    tick();
  endtask

  task automatic test_x0();
    // Held instruction "writes" x0; MEM also claims x0
    drive_id(32'h500, 5'd1, 1'b1, 32'h1, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd0, 1'b0, 16'h0000);
    tick();
    i_mem_rd_wen = 1'b1; i_mem_rd_waddr = 5'd0; i_mem_rd_wdata = 32'h1234;
    i_ex_result = 32'h5555;
    drive_id(32'h504, 5'd0, 1'b1, 32'hFFFF, 5'd0, 1'b1, 32'hEEEE, 32'h0, 1'b1, 5'd3, 1'b0, 16'h0003);
    checks++; if (o_stall !== 1'b0 || o_id_ready !== 1'b1) begin errors++; $display("FAIL x0_nostall got=%0b/%0b exp=0/1", o_stall, o_id_ready); end
    tick();
    checks++; if (o_ex_valid !== 1'b1 || o_ex_rs1_data !== 32'h0 || o_ex_rs2_data !== 32'h0) begin
      errors++; $display("FAIL x0_operand got=%0b/%h/%h exp=1/0/0", o_ex_valid, o_ex_rs1_data, o_ex_rs2_data); end
    i_mem_rd_wen = 1'b0;
    i_ex_result = 32'h0;
    idle_id();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drive_id(32'h600, 5'd1, 1'b1, 32'h1, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd12, 1'b1, 16'h00CC);
    tick();
    drive_id(32'h604, 5'd12, 1'b1, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd13, 1'b0, 16'h000D);
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL rms_stall got=%0b exp=1", o_stall); end
    i_rst = 1'b1;
    #1;
    checks++; if (o_id_ready !== 1'b0) begin errors++; $display("FAIL rms_ready got=%0b exp=0", o_id_ready); end
    tick();
    checks++; if (o_ex_valid !== 1'b0 || o_ex_pc !== 32'h0 || o_ex_is_load !== 1'b0 || o_ex_ctrl !== 16'h0) begin
      errors++; $display("FAIL rms_state got=%0b/%h/%0b/%h exp=0/0/0/0", o_ex_valid, o_ex_pc, o_ex_is_load, o_ex_ctrl); end
    i_rst = 1'b0;
    idle_id();
  endtask

  // Watchdog: all scenarios are short directed sequences.
  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_ex_hazard();
    test_load_use();
    test_backpressure();
    test_flush();
    test_x0();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
